// File: rtl/inst_mem_pkg.sv
// -----------------------------------------------------------------------------
// inst_mem_pkg
//   Shared definitions for the instruction memory and its program loader.
//   INST_ADDR_W / INST_W : geometry of the 256 x 16 instruction RAM.
//   HALT_WORD            : instruction word that terminates a program load.
//   ld_state_e           : loader FSM state encoding.
// -----------------------------------------------------------------------------
package inst_mem_pkg;

    localparam int INST_ADDR_W = 8;
    localparam int INST_W      = 16;

    localparam logic [INST_W-1:0] HALT_WORD = 16'hEFFF;

    typedef enum logic [2:0] {
        LD_IDLE  = 3'd0,
        LD_HI    = 3'd1,
        LD_LO    = 3'd2,
        LD_WRITE = 3'd3,
        LD_DONE  = 3'd4
    } ld_state_e;

endpackage

// File: rtl/inst_mem_loader.sv
// -----------------------------------------------------------------------------
// inst_mem_loader
//   Loads the instruction RAM from a byte stream. Byte pairs (high byte first)
//   are packed into instruction words and written to consecutive addresses
//   starting at 0. The core is held in reset for the whole session. A session
//   ends after the HALT word has been written, or after address 255 has been
//   written (overflow).
//
//   Ports
//     clk, rst_n      clock (rising edge), asynchronous active-low reset
//     start           one-cycle request to begin a load session
//     in_valid        byte available on in_data
//     in_data         stream byte
//     in_ready        loader accepts a byte this cycle (state only)
//     wr_en           RAM write strobe, one cycle per word
//     wr_addr         RAM write address
//     wr_data         RAM write data
//     core_hold       CPU reset hold, equal to busy
//     busy            load session active
//     done            last session finished (level)
//     overflow        last session ran out of memory without a HALT word
//     word_count      words written in the current or last session (0..256)
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   LD_IDLE  | after reset, session counters held clear, waiting for start
//   LD_HI    | waiting for the high byte of the next word
//   LD_LO    | high byte held, waiting for the low byte
//   LD_WRITE | word on wr_addr/wr_data, wr_en asserted for this one cycle
//   LD_DONE  | session finished, done high, waiting for a new start
// -----------------------------------------------------------------------------
module inst_mem_loader
    import inst_mem_pkg::*;
#(
    parameter int                ADDR_W    = INST_ADDR_W,
    parameter int                DATA_W    = INST_W,
    parameter logic [DATA_W-1:0] HALT_WORD = inst_mem_pkg::HALT_WORD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

    ld_state_e         state;
    ld_state_e         state_nxt;

    logic [7:0]        hi_byte;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W:0]   count_q;
    logic              overflow_q;

    logic              xfer;
    logic              session_clr;
    logic              is_halt;
    logic              addr_full;

    assign xfer        = in_valid && in_ready;
    // A start from DONE clears on the same edge that enters HI, so done and
    // overflow are already low in the first cycle of the new session.
    assign session_clr = (state == LD_IDLE) || ((state == LD_DONE) && start);
    assign is_halt     = (data_q == HALT_WORD);
    assign addr_full   = (addr_q == ADDR_LAST);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LD_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_nxt = state;
        unique case (state)
            LD_IDLE: begin
                if (start) begin
                    state_nxt = LD_HI;
                end
            end
            LD_HI: begin
                if (xfer) begin
                    state_nxt = LD_LO;
                end
            end
            LD_LO: begin
                if (xfer) begin
                    state_nxt = LD_WRITE;
                end
            end
            LD_WRITE: begin
                if (is_halt || addr_full) begin
                    state_nxt = LD_DONE;
                end else begin
                    state_nxt = LD_HI;
                end
            end
            LD_DONE: begin
                if (start) begin
                    state_nxt = LD_HI;
                end
            end
            default: state_nxt = LD_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    // Handshake and status depend on state only; in_ready never looks at
    // in_valid, which keeps the byte source free of combinational loops.
    always_comb begin
        in_ready  = 1'b0;
        wr_en     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            LD_HI: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            LD_LO: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            LD_WRITE: begin
                wr_en    = 1'b1;
                busy     = 1'b1;
            end
            LD_DONE: begin
                done     = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
        core_hold = busy;
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_byte    <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (session_clr) begin
                addr_q     <= '0;
                count_q    <= '0;
                overflow_q <= 1'b0;
            end

            if ((state == LD_HI) && xfer) begin
                hi_byte <= in_data;
            end

            if ((state == LD_LO) && xfer) begin
                data_q <= {hi_byte, in_data};
            end

            if (state == LD_WRITE) begin
                count_q <= count_q + CNT_ONE;
                // HALT takes priority: a HALT word at the last address is a
                // clean finish, not an overflow. The address is never advanced
                // past the last location.
                if (is_halt) begin
                    overflow_q <= 1'b0;
                end else if (addr_full) begin
                    overflow_q <= 1'b1;
                end else begin
                    addr_q <= addr_q + ADDR_ONE;
                end
            end
        end
    end

    assign wr_addr    = addr_q;
    assign wr_data    = data_q;
    assign word_count = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_inst_mem_loader
//   Self-checking bench for inst_mem_loader. A session-level model predicts
//   every output each cycle; an independent write list, computed straight
//   from the byte stream, checks the address/data of every wr_en pulse.
// -----------------------------------------------------------------------------
module tb_inst_mem_loader;
    import inst_mem_pkg::*;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b1;
    logic        start    = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data  = 8'h00;
    logic        in_ready;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        core_hold;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [8:0]  word_count;

    always #5 clk = ~clk;

    inst_mem_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .core_hold  (core_hold),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .word_count (word_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------ model
    // Session view: a session is active from start until its final word has
    // been written; every second accepted byte completes a word, which is
    // written in the following cycle.
    bit          m_active  = 0;
    bit          m_fin     = 0;
    bit          m_ovf     = 0;
    bit          m_hi_held = 0;
    bit          m_wpend   = 0;
    int          m_addr    = 0;
    int          m_count   = 0;
    logic [7:0]  m_hi      = 8'h00;
    logic [15:0] m_word    = 16'h0000;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; m_fin = 0; m_ovf = 0; m_hi_held = 0; m_wpend = 0;
            m_addr = 0; m_count = 0; m_hi = 8'h00; m_word = 16'h0000;
        end else if (m_wpend) begin
            m_wpend = 0;
            m_count = m_count + 1;
            if (m_word == 16'hEFFF) begin
                m_active = 0; m_fin = 1; m_ovf = 0;
            end else if (m_addr == 255) begin
                m_active = 0; m_fin = 1; m_ovf = 1;
            end else begin
                m_addr = m_addr + 1;
            end
        end else if (m_active) begin
            if (in_valid) begin
                if (!m_hi_held) begin
                    m_hi = in_data;
                    m_hi_held = 1;
                end else begin
                    m_word = {m_hi, in_data};
                    m_hi_held = 0;
                    m_wpend = 1;
                end
            end
        end else if (start) begin
            m_active = 1; m_fin = 0; m_ovf = 0;
            m_addr = 0; m_count = 0; m_hi_held = 0;
        end
    end

    // ------------------------------------------------------ expected writes
    logic [7:0]  stream[$];
    logic [15:0] exp_d[$];
    int          exp_a[$];
    logic [15:0] wl_data[$];
    int          wl_addr[$];
    int          n_wr = 0;

    task automatic plan_stream();
        int a;
        logic [15:0] w;
        a = 0;
        for (int i = 0; i + 1 < stream.size(); i += 2) begin
            w = {stream[i], stream[i+1]};
            exp_d.push_back(w);
            exp_a.push_back(a);
            if (w == 16'hEFFF || a == 255) break;
            a++;
        end
    endtask

    // ---------------------------------------------------------------- compare
    always @(negedge clk) begin
        chk("in_ready",   in_ready,   32'(m_active && !m_wpend));
        chk("wr_en",      wr_en,      32'(m_wpend));
        chk("busy",       busy,       32'(m_active));
        chk("core_hold",  core_hold,  32'(m_active));
        chk("done",       done,       32'(m_fin));
        chk("overflow",   overflow,   32'(m_ovf));
        chk("word_count", word_count, 32'(m_count));
        chk("wr_addr",    wr_addr,    32'(m_addr));
        chk("wr_data",    wr_data,    32'(m_word));
        if (wr_en === 1'b1) begin
            n_wr++;
            wl_data.push_back(wr_data);
            wl_addr.push_back(int'(wr_addr));
            if (exp_d.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", wr_addr, wr_data);
            end else begin
                chk("sb_addr", 32'(wr_addr), 32'(exp_a.pop_front()));
                chk("sb_data", 32'(wr_data), 32'(exp_d.pop_front()));
            end
        end
    end

    // --------------------------------------------------------------- stimulus
    task automatic send_byte(input logic [7:0] b, input int maxgap);
        int gap;
        bit got;
        gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
        got = 0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        // in_ready is state-driven, so its value now is its value at the edge
        for (int t = 0; t < 60 && !got; t++) begin
            got = in_ready;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL byte_timeout: got no in_ready, expected acceptance of %0h", b);
        end
    endtask

    task automatic send_stream(input int maxgap);
        for (int i = 0; i < stream.size(); i++) send_byte(stream[i], maxgap);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        bit seen;
        seen = 0;
        for (int t = 0; t < 100 && !seen; t++) begin
            if (done === 1'b1) seen = 1;
            else @(negedge clk);
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_done_timeout: got done=%b, expected 1", nm, done);
        end
    endtask

    task automatic new_session_logs();
        wl_data.delete();
        wl_addr.delete();
        n_wr = 0;
    endtask

    task automatic set_basic_stream();
        stream.delete();
        stream.push_back(8'h9A); stream.push_back(8'h35);
        stream.push_back(8'h9A); stream.push_back(8'h7F);
        stream.push_back(8'hEF); stream.push_back(8'hFF);
    endtask

    task automatic set_short_stream();
        stream.delete();
        stream.push_back(8'h00); stream.push_back(8'h01);
        stream.push_back(8'hEF); stream.push_back(8'hFF);
    endtask

    task automatic check_reset_values(input string nm);
        chk({nm, "_in_ready"},   in_ready,   0);
        chk({nm, "_wr_en"},      wr_en,      0);
        chk({nm, "_wr_addr"},    wr_addr,    0);
        chk({nm, "_wr_data"},    wr_data,    0);
        chk({nm, "_core_hold"},  core_hold,  0);
        chk({nm, "_busy"},       busy,       0);
        chk({nm, "_done"},       done,       0);
        chk({nm, "_overflow"},   overflow,   0);
        chk({nm, "_word_count"}, word_count, 0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 check_reset_values("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back stream ending in HALT
        set_basic_stream();
        plan_stream();
        new_session_logs();
        pulse_start();
        send_stream(0);
        wait_done("t1");
        chk("t1_nwr",   n_wr, 3);
        chk("t1_a0",    wl_addr[0], 0);
        chk("t1_d0",    wl_data[0], 16'h9A35);
        chk("t1_a1",    wl_addr[1], 1);
        chk("t1_d1",    wl_data[1], 16'h9A7F);
        chk("t1_a2",    wl_addr[2], 2);
        chk("t1_d2",    wl_data[2], 16'hEFFF);
        chk("t1_done",  done, 1);
        chk("t1_ovf",   overflow, 0);
        chk("t1_count", word_count, 3);
        chk("t1_hold",  core_hold, 0);
        chk("t1_sb_empty", exp_d.size(), 0);

        // Same stream with random stalls on in_valid
        for (int rep = 0; rep < 4; rep++) begin
            set_basic_stream();
            plan_stream();
            new_session_logs();
            pulse_start();
            send_stream(5);
            wait_done("t2");
            chk("t2_nwr",   n_wr, 3);
            chk("t2_d1",    wl_data[1], 16'h9A7F);
            chk("t2_count", word_count, 3);
            chk("t2_sb_empty", exp_d.size(), 0);
        end

        // start pulses during LO and during WRITE are ignored
        stream.delete();
        stream.push_back(8'h12); stream.push_back(8'h34);
        stream.push_back(8'hEF); stream.push_back(8'hFF);
        plan_stream();
        new_session_logs();
        pulse_start();
        send_byte(8'h12, 0);
        pulse_start();
        send_byte(8'h34, 0);
        chk("t3_in_write", wr_en, 1);
        pulse_start();
        send_byte(8'hEF, 2);
        send_byte(8'hFF, 2);
        wait_done("t3");
        chk("t3_nwr",   n_wr, 2);
        chk("t3_a0",    wl_addr[0], 0);
        chk("t3_d0",    wl_data[0], 16'h1234);
        chk("t3_a1",    wl_addr[1], 1);
        chk("t3_count", word_count, 2);
        chk("t3_sb_empty", exp_d.size(), 0);

        // Fill all 256 words without a HALT
        stream.delete();
        for (int i = 0; i < 256; i++) begin
            stream.push_back(8'h12);
            stream.push_back(8'h34);
        end
        plan_stream();
        new_session_logs();
        pulse_start();
        send_stream(0);
        wait_done("t4");
        chk("t4_nwr",    n_wr, 256);
        chk("t4_alast",  wl_addr[255], 255);
        chk("t4_dlast",  wl_data[255], 16'h1234);
        chk("t4_done",   done, 1);
        chk("t4_ovf",    overflow, 1);
        chk("t4_count",  word_count, 256);
        in_valid = 1'b1;
        in_data  = 8'h56;
        repeat (6) @(negedge clk);
        in_valid = 1'b0;
        chk("t4_no_more_writes", n_wr, 256);
        chk("t4_sb_empty", exp_d.size(), 0);

        // Restart from DONE clears done/overflow on the start edge
        set_short_stream();
        plan_stream();
        new_session_logs();
        pulse_start();
        chk("t5_done_clr", done, 0);
        chk("t5_ovf_clr",  overflow, 0);
        chk("t5_busy",     busy, 1);
        chk("t5_ready",    in_ready, 1);
        send_stream(3);
        wait_done("t5");
        chk("t5_a0",    wl_addr[0], 0);
        chk("t5_d0",    wl_data[0], 16'h0001);
        chk("t5_a1",    wl_addr[1], 1);
        chk("t5_d1",    wl_data[1], 16'hEFFF);
        chk("t5_count", word_count, 2);
        chk("t5_ovf",   overflow, 0);
        chk("t5_sb_empty", exp_d.size(), 0);

        // Reset after the high byte of word 5
        stream.delete();
        for (int i = 0; i < 10; i++) stream.push_back(8'(8'h20 + i));
        plan_stream();
        new_session_logs();
        pulse_start();
        send_stream(1);
        send_byte(8'h77, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_values("mid_rst");
        chk("t6_nwr", n_wr, 5);
        exp_d.delete();
        exp_a.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_short_stream();
        plan_stream();
        new_session_logs();
        pulse_start();
        send_stream(2);
        wait_done("t6");
        chk("t6_a0",    wl_addr[0], 0);
        chk("t6_d0",    wl_data[0], 16'h0001);
        chk("t6_count", word_count, 2);
        chk("t6_sb_empty", exp_d.size(), 0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of run, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
